// File: rtl/gpu_pkg.sv
// Shared GPU register-file definitions: read-only register offsets, default widths
// and a helper that classifies a register address.
package gpu_pkg;

    localparam int DEFAULT_NUM_LANES     = 16;
    localparam int DEFAULT_DATA_WIDTH    = 64;
    localparam int DEFAULT_NUM_REGISTERS = 32;

    // Offsets are counted down from NUM_REGISTERS
    localparam int REG_BLOCK_IDX_OFS  = 4;
    localparam int REG_BLOCK_DIM_OFS  = 3;
    localparam int REG_THREAD_IDX_OFS = 2;
    localparam int REG_ZERO_OFS       = 1;

    typedef enum logic [2:0] {
        RC_GPR,
        RC_BLOCK_IDX,
        RC_BLOCK_DIM,
        RC_THREAD_IDX,
        RC_ZERO
    } reg_class_e;

    function automatic reg_class_e reg_class(input int addr, input int nregs);
        if (addr == nregs - REG_ZERO_OFS)       return RC_ZERO;
        if (addr == nregs - REG_THREAD_IDX_OFS) return RC_THREAD_IDX;
        if (addr == nregs - REG_BLOCK_DIM_OFS)  return RC_BLOCK_DIM;
        if (addr == nregs - REG_BLOCK_IDX_OFS)  return RC_BLOCK_IDX;
        return RC_GPR;
    endfunction

endpackage

// File: rtl/warp_reg_file_if.sv
// Issue/writeback bus of the warp register file; the pipeline drives it through
// the master modport, the register file sits on the slave modport.
interface warp_reg_file_if #(
    parameter int NUM_LANES      = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                            enable;
    logic signed [31:0]              block_id;
    logic        [31:0]              block_dim;
    logic [REG_ADDR_WIDTH-1:0]       rm;
    logic [REG_ADDR_WIDTH-1:0]       rn;
    logic [NUM_LANES*DATA_WIDTH-1:0] rm_data;
    logic [NUM_LANES*DATA_WIDTH-1:0] rn_data;
    logic                            rd_valid;
    logic                            wr_en;
    logic [REG_ADDR_WIDTH-1:0]       wr_rd;
    logic [NUM_LANES-1:0]            wr_lane_mask;
    logic [NUM_LANES*DATA_WIDTH-1:0] wr_data;
    logic                            rsv_en;
    logic [REG_ADDR_WIDTH-1:0]       rsv_rd;
    logic [REG_ADDR_WIDTH-1:0]       chk_rd;
    logic                            hazard;

    modport master (
        output enable, block_id, block_dim, rm, rn, wr_en, wr_rd, wr_lane_mask,
               wr_data, rsv_en, rsv_rd, chk_rd,
        input  rm_data, rn_data, rd_valid, hazard
    );

    modport slave (
        input  enable, block_id, block_dim, rm, rn, wr_en, wr_rd, wr_lane_mask,
               wr_data, rsv_en, rsv_rd, chk_rd,
        output rm_data, rn_data, rd_valid, hazard
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, looked up for hazards.
module reg_scoreboard
    import gpu_pkg::*;
#(
    parameter int NUM_REGISTERS  = DEFAULT_NUM_REGISTERS,
    parameter int REG_ADDR_WIDTH = $clog2(NUM_REGISTERS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] set_addr_i,
    input  logic                      clr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] clr_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rm_i,
    input  logic [REG_ADDR_WIDTH-1:0] rn_i,
    input  logic [REG_ADDR_WIDTH-1:0] chk_i,
    output logic                      hazard_o
);
    logic [NUM_REGISTERS-1:0] busy_q;
    logic [NUM_REGISTERS-1:0] busy_d;

    // Set is applied after clear so a same-cycle reservation wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign hazard_o = busy_q[rm_i] | busy_q[rn_i] | busy_q[chk_i];

endmodule

// File: rtl/warp_reg_file.sv
// SIMT warp register file: per-lane GPRs with masked writeback and write-to-read
// bypass, read-only launch registers, and a busy-bit scoreboard.
module warp_reg_file
    import gpu_pkg::*;
#(
    parameter int NUM_LANES      = DEFAULT_NUM_LANES,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGISTERS  = DEFAULT_NUM_REGISTERS,
    parameter int REG_ADDR_WIDTH = $clog2(NUM_REGISTERS),
    parameter int THREAD_ID_BASE = 0
) (
    input logic           clk,
    input logic           rst,
    warp_reg_file_if.slave bus
);
    localparam int NUM_GPR = NUM_REGISTERS - REG_BLOCK_IDX_OFS;
    localparam int VEC_W   = NUM_LANES * DATA_WIDTH;

    logic [DATA_WIDTH-1:0]     gpr_q [NUM_LANES][NUM_GPR];
    logic [DATA_WIDTH-1:0]     blk_idx_q;
    logic [DATA_WIDTH-1:0]     blk_dim_q;
    logic [VEC_W-1:0]          rd_data_q [2];
    logic [VEC_W-1:0]          rd_data_d [2];
    logic                      rd_valid_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr [2];
    logic                      wr_act;
    logic                      wr_gpr;
    logic                      rsv_act;

    assign rd_addr[0] = bus.rm;
    assign rd_addr[1] = bus.rn;
    assign wr_act  = bus.enable & bus.wr_en;
    assign wr_gpr  = wr_act & (reg_class(32'(bus.wr_rd), NUM_REGISTERS) == RC_GPR);
    assign rsv_act = bus.enable & bus.rsv_en
                   & (reg_class(32'(bus.rsv_rd), NUM_REGISTERS) == RC_GPR);

    function automatic logic [DATA_WIDTH-1:0] lane_value(
        input reg_class_e            cls,
        input logic                  bypass,
        input logic [DATA_WIDTH-1:0] gpr_val,
        input logic [DATA_WIDTH-1:0] wr_val,
        input logic [DATA_WIDTH-1:0] bidx,
        input logic [DATA_WIDTH-1:0] bdim,
        input int                    lane
    );
        case (cls)
            RC_GPR:        return bypass ? wr_val : gpr_val;
            RC_BLOCK_IDX:  return bidx;
            RC_BLOCK_DIM:  return bdim;
            RC_THREAD_IDX: return DATA_WIDTH'($unsigned(THREAD_ID_BASE + lane));
            default:       return '0;
        endcase
    endfunction

    // Read ports: a GPR being written this cycle returns the new data on enabled lanes
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_d[p] = rd_data_q[p];
            if (bus.enable) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    rd_data_d[p][l*DATA_WIDTH +: DATA_WIDTH] = lane_value(
                        reg_class(32'(rd_addr[p]), NUM_REGISTERS),
                        wr_act && (bus.wr_rd == rd_addr[p]) && bus.wr_lane_mask[l],
                        gpr_q[l][rd_addr[p]],
                        bus.wr_data[l*DATA_WIDTH +: DATA_WIDTH],
                        blk_idx_q, blk_dim_q, l);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < NUM_LANES; l++)
                for (int r = 0; r < NUM_GPR; r++)
                    gpr_q[l][r] <= '0;
            blk_idx_q    <= DATA_WIDTH'(bus.block_id);
            blk_dim_q    <= DATA_WIDTH'(bus.block_dim);
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            if (wr_gpr) begin
                for (int l = 0; l < NUM_LANES; l++)
                    if (bus.wr_lane_mask[l])
                        gpr_q[l][bus.wr_rd] <= bus.wr_data[l*DATA_WIDTH +: DATA_WIDTH];
            end
            rd_data_q[0] <= rd_data_d[0];
            rd_data_q[1] <= rd_data_d[1];
            rd_valid_q   <= bus.enable;
        end
    end

    assign bus.rm_data  = rd_data_q[0];
    assign bus.rn_data  = rd_data_q[1];
    assign bus.rd_valid = rd_valid_q;

    reg_scoreboard #(
        .NUM_REGISTERS (NUM_REGISTERS),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en_i  (rsv_act),
        .set_addr_i(bus.rsv_rd),
        .clr_en_i  (wr_act),
        .clr_addr_i(bus.wr_rd),
        .rm_i      (bus.rm),
        .rn_i      (bus.rn),
        .chk_i     (bus.chk_rd),
        .hazard_o  (bus.hazard)
    );

endmodule

// File: tb/tb_warp_reg_file.sv
// Bench for warp_reg_file: expected read data is queued when a read is issued and
// checked once the registered outputs appear.
module tb_warp_reg_file;
    localparam int NL = 16;
    localparam int DW = 64;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int VW = NL * DW;

    typedef struct {
        string       name;
        bit          port;   // 0: rm_data, 1: rn_data
        int          lane;
        logic [63:0] val;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sbq[$];
    exp_t e;
    logic [63:0] got;
    int n_cmp = 0;
    int n_bad = 0;

    warp_reg_file_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    warp_reg_file #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .NUM_REGISTERS(NR),
        .REG_ADDR_WIDTH(AW), .THREAD_ID_BASE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] lane_of(input logic [VW-1:0] v, input int l);
        return v[l*DW +: DW];
    endfunction

    function automatic logic [VW-1:0] splat(input logic [63:0] x);
        logic [VW-1:0] v;
        for (int l = 0; l < NL; l++) v[l*DW +: DW] = x;
        return v;
    endfunction

    task automatic push(input string n, input bit port, input int lane, input logic [63:0] v);
        exp_t x;
        x.name = n; x.port = port; x.lane = lane; x.val = v;
        sbq.push_back(x);
    endtask

    task automatic set_idle();
        rst = 1'b0;
        bus.enable = 1'b1;
        bus.wr_en = 1'b0; bus.wr_rd = '0; bus.wr_lane_mask = '0; bus.wr_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_rd = '0;
        bus.rm = '0; bus.rn = '0; bus.chk_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        bus.block_id = -32'sd2; bus.block_dim = 32'd64;
        bus.wr_en = 1'b1; bus.wr_rd = 5'd5; bus.wr_lane_mask = '1; bus.wr_data = splat(64'hDEAD);
        bus.rsv_en = 1'b1; bus.rsv_rd = 5'd5; bus.rm = 5'd5; bus.chk_rd = 5'd5;
        tick();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
        n_cmp++; if (bus.rm_data !== '0) begin n_bad++; $display("FAIL reset_rm_data got %h exp 0", bus.rm_data[63:0]); end
        n_cmp++; if (bus.rn_data !== '0) begin n_bad++; $display("FAIL reset_rn_data got %h exp 0", bus.rn_data[63:0]); end
        n_cmp++; if (bus.hazard !== 1'b0) begin n_bad++; $display("FAIL reset_hazard got %b exp 0", bus.hazard); end
        set_idle(); bus.rm = 5'd28; bus.rn = 5'd29;
        push("blockIdx", 0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        push("blockIdx", 0, 15, 64'hFFFF_FFFF_FFFF_FFFE);
        push("blockDim", 1, 0, 64'd64);
        push("blockDim", 1, 15, 64'd64);
        tick();
        n_cmp++; if (bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL ro_rd_valid got %b exp 1", bus.rd_valid); end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
        bus.rm = 5'd30; bus.rn = 5'd31;
        push("threadIdx", 0, 0, 64'd16);
        push("threadIdx", 0, 7, 64'd23);
        push("threadIdx", 0, 15, 64'd31);
        push("zero_reg", 1, 0, 64'd0);
        push("zero_reg", 1, 15, 64'd0);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
    endtask

    task automatic test_masked_write();
        set_idle();
        bus.wr_en = 1'b1; bus.wr_rd = 5'd5; bus.wr_lane_mask = 16'h0001; bus.wr_data = splat(64'hAA);
        tick();
        set_idle(); bus.rm = 5'd5; bus.rn = 5'd5;
        for (int l = 0; l < NL; l++) push("masked_wr", 0, l, (l == 0) ? 64'hAA : 64'h0);
        push("masked_wr_rn", 1, 0, 64'hAA);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
    endtask

    task automatic test_bypass();
        set_idle();
        bus.wr_en = 1'b1; bus.wr_rd = 5'd7; bus.wr_lane_mask = '1;
        for (int l = 0; l < NL; l++) bus.wr_data[l*DW +: DW] = 64'h1000 + 64'(l);
        tick();
        set_idle();
        bus.wr_en = 1'b1; bus.wr_rd = 5'd7; bus.wr_lane_mask = 16'h00FF; bus.wr_data = splat(64'h55);
        bus.rm = 5'd7; bus.rn = 5'd8;
        for (int l = 0; l < NL; l++) push("bypass", 0, l, (l < 8) ? 64'h55 : 64'h1000 + 64'(l));
        push("bypass_other_reg", 1, 3, 64'h0);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
        set_idle(); bus.rm = 5'd7;
        for (int l = 0; l < NL; l += 5) push("after_bypass", 0, l, (l < 8) ? 64'h55 : 64'h1000 + 64'(l));
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
    endtask

    task automatic test_readonly();
        set_idle();
        bus.wr_en = 1'b1; bus.wr_rd = 5'd31; bus.wr_lane_mask = '1; bus.wr_data = splat(64'h123);
        bus.rsv_en = 1'b1; bus.rsv_rd = 5'd31; bus.rm = 5'd31;
        push("r31_same_cycle", 0, 0, 64'h0);
        push("r31_same_cycle", 0, 15, 64'h0);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
        set_idle();
        bus.wr_en = 1'b1; bus.wr_rd = 5'd28; bus.wr_lane_mask = '1; bus.wr_data = splat(64'h123);
        bus.rsv_en = 1'b1; bus.rsv_rd = 5'd28; bus.rm = 5'd28; bus.chk_rd = 5'd31;
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_bad++; $display("FAIL r31_busy got %b exp 0", bus.hazard); end
        push("r28_same_cycle", 0, 9, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
        set_idle(); bus.rm = 5'd31; bus.rn = 5'd28; bus.chk_rd = 5'd28;
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_bad++; $display("FAIL r28_busy got %b exp 0", bus.hazard); end
        push("r31_after_wr", 0, 4, 64'h0);
        push("r28_after_wr", 1, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        push("r28_after_wr", 1, 15, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
    endtask

    task automatic test_scoreboard();
        set_idle(); bus.chk_rd = 5'd3; bus.rsv_en = 1'b1; bus.rsv_rd = 5'd3;
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_bad++; $display("FAIL hazard_before_rsv got %b exp 0", bus.hazard); end
        tick();
        set_idle(); bus.chk_rd = 5'd3;
        #1;
        n_cmp++; if (bus.hazard !== 1'b1) begin n_bad++; $display("FAIL hazard_rsv got %b exp 1", bus.hazard); end
        bus.rsv_en = 1'b1; bus.rsv_rd = 5'd3; bus.wr_en = 1'b1; bus.wr_rd = 5'd3;
        tick();
        set_idle(); bus.chk_rd = 5'd3; bus.wr_en = 1'b1; bus.wr_rd = 5'd3; bus.wr_lane_mask = '0;
        #1;
        n_cmp++; if (bus.hazard !== 1'b1) begin n_bad++; $display("FAIL hazard_rsv_wins got %b exp 1", bus.hazard); end
        tick();
        set_idle(); bus.chk_rd = 5'd3;
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_bad++; $display("FAIL hazard_cleared got %b exp 0", bus.hazard); end
        bus.rsv_en = 1'b1; bus.rsv_rd = 5'd9;
        tick();
        set_idle(); bus.enable = 1'b0; bus.rm = 5'd9;
        #1;
        n_cmp++; if (bus.hazard !== 1'b1) begin n_bad++; $display("FAIL hazard_rm_disabled got %b exp 1", bus.hazard); end
        bus.rm = 5'd0; bus.rn = 5'd9;
        #1;
        n_cmp++; if (bus.hazard !== 1'b1) begin n_bad++; $display("FAIL hazard_rn got %b exp 1", bus.hazard); end
        bus.enable = 1'b1; bus.wr_en = 1'b1; bus.wr_rd = 5'd9;
        tick();
        set_idle(); bus.rn = 5'd9;
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_bad++; $display("FAIL hazard_rn_cleared got %b exp 0", bus.hazard); end
    endtask

    task automatic test_disable();
        set_idle(); bus.rm = 5'd5;
        push("pre_disable", 0, 0, 64'hAA);
        push("pre_disable", 0, 1, 64'h0);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
        set_idle(); bus.enable = 1'b0;
        bus.wr_en = 1'b1; bus.wr_rd = 5'd5; bus.wr_lane_mask = '1; bus.wr_data = splat(64'hBB);
        bus.rsv_en = 1'b1; bus.rsv_rd = 5'd6; bus.rm = 5'd7;
        push("disabled_hold", 0, 0, 64'hAA);
        push("disabled_hold", 0, 1, 64'h0);
        tick();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL disabled_rd_valid got %b exp 0", bus.rd_valid); end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
        set_idle(); bus.rm = 5'd5; bus.chk_rd = 5'd6;
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_bad++; $display("FAIL disabled_rsv got %b exp 0", bus.hazard); end
        push("disabled_no_write", 0, 0, 64'hAA);
        push("disabled_no_write", 0, 1, 64'h0);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            set_idle();
            if (i < 4) begin
                bus.wr_en = 1'b1; bus.wr_rd = 5'(10 + i); bus.wr_lane_mask = '1;
                for (int l = 0; l < NL; l++) bus.wr_data[l*DW +: DW] = 64'((i + 1) * 256 + l);
                bus.rn = 5'(10 + i);
                push("b2b_bypass", 1, 5, 64'((i + 1) * 256 + 5));
            end
            if (i > 0) begin
                bus.rm = 5'(10 + i - 1);
                push("b2b_prev", 0, 0, 64'(i * 256));
                push("b2b_prev", 0, 15, 64'(i * 256 + 15));
            end
            tick();
            n_cmp++; if (bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_valid got %b exp 1", bus.rd_valid); end
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
                n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
            end
        end
    endtask

    task automatic test_mid_reset();
        set_idle(); bus.rsv_en = 1'b1; bus.rsv_rd = 5'd4;
        tick();
        set_idle(); bus.chk_rd = 5'd4;
        #1;
        n_cmp++; if (bus.hazard !== 1'b1) begin n_bad++; $display("FAIL pre_reset_hazard got %b exp 1", bus.hazard); end
        rst = 1'b1; bus.block_id = 32'sd5; bus.block_dim = 32'd128;
        bus.rm = 5'd10; bus.rn = 5'd28;
        bus.wr_en = 1'b1; bus.wr_rd = 5'd11; bus.wr_lane_mask = '1; bus.wr_data = splat(64'h77);
        tick();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_rd_valid got %b exp 0", bus.rd_valid); end
        n_cmp++; if (bus.rm_data !== '0) begin n_bad++; $display("FAIL mid_reset_rm_data got %h exp 0", bus.rm_data[63:0]); end
        n_cmp++; if (bus.rn_data !== '0) begin n_bad++; $display("FAIL mid_reset_rn_data got %h exp 0", bus.rn_data[63:0]); end
        n_cmp++; if (bus.hazard !== 1'b0) begin n_bad++; $display("FAIL mid_reset_hazard got %b exp 0", bus.hazard); end
        set_idle(); bus.rm = 5'd10; bus.rn = 5'd28;
        push("gpr_cleared", 0, 0, 64'h0);
        push("blockIdx_reload", 1, 15, 64'd5);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
        bus.rm = 5'd29; bus.rn = 5'd11;
        push("blockDim_reload", 0, 0, 64'd128);
        push("write_under_reset", 1, 2, 64'h0);
        tick();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.port ? lane_of(bus.rn_data, e.lane) : lane_of(bus.rm_data, e.lane);
            n_cmp++; if (got !== e.val) begin n_bad++; $display("FAIL %s lane%0d got %h exp %h", e.name, e.lane, got, e.val); end
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        bus.block_id = '0;
        bus.block_dim = '0;
        test_reset();
        test_masked_write();
        test_bypass();
        test_readonly();
        test_scoreboard();
        test_disable();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
